esn_readout_streamer: RTL
=========================

Name: esn_readout_streamer

Overview:
- Sits on the output side of the ESN top level.
- On a snapshot strobe, captures the current estimate `est` and the packed output-weight vector `W_out` into a holding register.
- Transmits the capture as a framed stream of WIDTH-bit words over a valid/ready interface toward host logging or a UART/DMA bridge.
- Lets the host read training progress (W_out) and estimates without stalling the ESN datapath.

Parameters:
- N_OUT, 8, number of output weights packed in W_out.
- WIDTH, 32, bit width of est, of each weight and of each stream word.
- HDR_TAG, 16'hE5A0, upper half of the frame header word.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- snap  input  1  single-cycle capture request.
- est  input  WIDTH  current ESN estimate.
- W_out  input  N_OUT*WIDTH  packed weights; element i is W_out[i*WIDTH +: WIDTH].
- m_data  output  WIDTH  stream word.
- m_valid  output  1  m_data is valid.
- m_ready  input  1  downstream accepts a word when m_valid && m_ready.
- m_last  output  1  asserted with the final word of a frame.
- busy  output  1  a frame is captured and not yet fully sent.
- frame_cnt  output  16  count of completed frames.
- drop_cnt  output  16  count of rejected snap requests; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs and the FSM clear at that edge.
  - m_valid=0, m_last=0, busy=0, m_data=0, frame_cnt=0, drop_cnt=0, FSM=IDLE.
  - rst mid-frame aborts the frame; nothing further is sent and frame_cnt is unchanged.
- FSM states: IDLE, HDR, EST, WGT, CSUM.
  - IDLE: on snap, latch est, all of W_out and frame_cnt; go to HDR.
  - HDR to EST, EST to WGT, and CSUM to end-of-frame each advance on a handshake.
  - WGT holds index i = 0..N_OUT-1 and advances i per handshake; after i=N_OUT-1 it goes to CSUM.
- Frame: N_OUT+3 words (11 at defaults), in this order:
  - header = {HDR_TAG, latched frame_cnt};
  - latched est;
  - W_out elements 0 through N_OUT-1;
  - checksum = XOR of all preceding words of the frame.
- Latency: snap sampled at edge k; m_valid=1 with the header after edge k.
- Stream rules:
  - Once m_valid is asserted, m_valid and m_data hold stable until a handshake.
  - m_valid never drops without a handshake except on rst.
  - The next word is presented the cycle after a handshake; a continuously high m_ready yields one word per cycle with no bubbles.
  - m_last=1 only alongside the checksum word.
- busy:
  - rises on the edge that captures snap;
  - falls on the edge completing the checksum handshake, unless a new snap is accepted on that same edge.
- Snapshot isolation: est/W_out changes after capture do not affect the frame in flight.
- snap while busy: ignored and drop_cnt increments (saturating).
  - Exception: snap coinciding with the final checksum handshake is accepted.
  - In that case the new header appears the next cycle, back-to-back.
- frame_cnt increments by 1 on each completed checksum handshake and wraps FFFF to 0000.
  - In a back-to-back frame, the header carries the incremented value.
- Checksum: a running XOR register cleared when a frame starts and updated with each word as it is handshaken.

Test Plan:
- Basic frame:
  - Stimulus: rst, then est=32'h0000_1234, W_out[i]=32'h1000_0000+i, snap pulse, m_ready held 1.
  - Response: 11 consecutive words: E5A0_0000, 0000_1234, 1000_0000..1000_0007, then checksum (XOR of all ten, computed by the model).
  - m_last only on word 11; frame_cnt=1 after; busy low after.
- Backpressure:
  - Stimulus: same frame, m_ready toggling pseudo-randomly, and est/W_out altered after capture.
  - Response: identical word sequence; m_data stable across every stalled cycle; altered inputs never appear.
- Drop:
  - Stimulus: 3 snap pulses during frame transmission.
  - Response: drop_cnt=3; only one frame sent.
  - Stimulus: snap coinciding with the checksum handshake.
  - Response: second header E5A0_0001 next cycle.
- Reset mid-frame:
  - Stimulus: assert rst after word 4 handshake.
  - Response: m_valid=0, busy=0, frame_cnt=0 next cycle; the next snap starts a fresh frame with header E5A0_0000.
- Counter wrap/saturate:
  - Stimulus: force 65536 frames (or preload via hierarchical deposit).
  - Response: header wraps to E5A0_0000 and frame_cnt wraps to 0.
  - Stimulus: force drop_cnt=FFFF, then one more dropped snap.
  - Response: drop_cnt stays FFFF.

Source files
------------

// File: rtl/esn_readout_streamer.sv
// esn_readout_streamer: snapshots est and W_out, then streams them as a checksummed frame
module esn_readout_streamer #(
  parameter int          N_OUT   = 8,
  parameter int          WIDTH   = 32,
  parameter logic [15:0] HDR_TAG = 16'hE5A0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   snap,
  input  logic [WIDTH-1:0]       est,
  input  logic [N_OUT*WIDTH-1:0] W_out,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt
);
  localparam int IW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  typedef enum logic [2:0] {IDLE, HDR, EST, WGT, CSUM} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] est_q, est_d;
  logic [WIDTH-1:0] w_q [N_OUT];
  logic [WIDTH-1:0] w_d [N_OUT];
  logic [WIDTH-1:0] csum_q, csum_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             hs, done, accept;
  // next-state: a snap accepted on the final handshake starts the next frame with no gap
  always_comb begin
    hs          = m_valid_q & m_ready;
    done        = hs && state_q == CSUM;
    accept      = snap && (state_q == IDLE || done);
    state_d     = state_q;
    idx_d       = idx_q;
    est_d       = est_q;
    w_d         = w_q;
    csum_d      = csum_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q + 16'(done);
    drop_cnt_d  = (snap && !accept && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    if (accept) begin
      est_d = est;
      for (int i = 0; i < N_OUT; i++) w_d[i] = W_out[i*WIDTH +: WIDTH];
      state_d   = HDR;
      csum_d    = '0;
      m_data_d  = WIDTH'({HDR_TAG, frame_cnt_d});
      m_valid_d = 1'b1;
      m_last_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (hs) begin
      csum_d = csum_q ^ m_data_q;
      case (state_q)
        HDR: begin
          state_d  = EST;
          m_data_d = est_q;
        end
        EST: begin
          state_d  = WGT;
          idx_d    = '0;
          m_data_d = w_q[0];
        end
        WGT: begin
          state_d  = idx_q == IW'(N_OUT - 1) ? CSUM : WGT;
          idx_d    = idx_q + 1'b1;
          m_data_d = idx_q == IW'(N_OUT - 1) ? csum_d : w_q[idx_d];
          m_last_d = idx_q == IW'(N_OUT - 1);
        end
        CSUM: begin
          state_d   = IDLE;
          m_data_d  = '0;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          busy_d    = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // control, stream and counter registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      csum_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
  // snapshot holding registers; contents only matter once a frame is captured
  always_ff @(posedge clk) begin
    est_q <= est_d;
    w_q   <= w_d;
  end
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
endmodule
